// File: rtl/dec_pkg.sv
// Shared decoder definitions: mode constants, buffer state encoding and the
// index-to-vector decode function used by the pipelined and combinational decoders.
package dec_pkg;

    localparam int unsigned MODE_ONEHOT = 0;
    localparam int unsigned MODE_THERMO = 1;

    // Widest supported index (IN_W <= 8) and therefore widest vector (2**8).
    localparam int unsigned DEC_IDX_W = 8;
    localparam int unsigned DEC_MAX_W = 256;

    typedef struct packed {
        logic                 err;
        logic [DEC_MAX_W-1:0] vec;
    } dec_res_t;

    // Skid buffer state, encoded as {M.valid, S.valid}; 2'b01 is never entered.
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'b00,
        BUF_ONE   = 2'b10,
        BUF_FULL  = 2'b11
    } buf_state_t;

    // Decode idx into a one-hot or thermometer vector of out_w bits; callers
    // slice the low out_w bits. err flags an enabled index >= out_w.
    function automatic dec_res_t dec_vec(
        input logic [DEC_IDX_W-1:0] idx,
        input logic                 en,
        input int unsigned          out_w,
        input int unsigned          mode
    );
        dec_res_t    res;
        logic        in_range;
        int unsigned idx_ext;
        idx_ext  = 32'(idx);
        in_range = (idx_ext < out_w);
        res.err  = en && !in_range;
        res.vec  = '0;
        for (int unsigned i = 0; i < DEC_MAX_W; i++) begin
            if (mode == MODE_THERMO) begin
                res.vec[DEC_IDX_W'(i)] = en && in_range && (i < out_w) && (i <= idx_ext);
            end else begin
                res.vec[DEC_IDX_W'(i)] = en && in_range && (i < out_w) && (i == idx_ext);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dec_skid_buf.sv
// Generic two-entry valid/ready skid buffer. in_ready depends only on state
// and reset, so neither the forward nor the backward path is combinational.
module dec_skid_buf
    import dec_pkg::*;
#(
    parameter int unsigned DATA_W = 33
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    buf_state_t        r_state;
    buf_state_t        w_state_nxt;
    logic [DATA_W-1:0] r_m_data;
    logic [DATA_W-1:0] r_s_data;
    logic [DATA_W-1:0] w_m_nxt;
    logic [DATA_W-1:0] w_s_nxt;
    logic              w_m_valid;
    logic              w_s_valid;
    logic              w_in_fire;
    logic [1:0]        w_state_bits;

    assign w_state_bits = r_state;
    assign w_m_valid    = w_state_bits[1];
    assign w_s_valid    = w_state_bits[0];

    assign in_ready  = !w_s_valid && !reset;
    assign out_valid = w_m_valid;
    assign out_data  = r_m_data;
    assign w_in_fire = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= BUF_EMPTY;
            r_m_data <= '0;
            r_s_data <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_m_data <= w_m_nxt;
            r_s_data <= w_s_nxt;
        end
    end

    // Next-state and data steering; S only fills when M is stalled.
    always_comb begin
        w_state_nxt = r_state;
        w_m_nxt     = r_m_data;
        w_s_nxt     = r_s_data;
        case (r_state)
            BUF_EMPTY: begin
                if (w_in_fire) begin
                    w_state_nxt = BUF_ONE;
                    w_m_nxt     = in_data;
                end
            end
            BUF_ONE: begin
                if (w_in_fire && out_ready) begin
                    w_m_nxt = in_data;
                end else if (w_in_fire) begin
                    w_state_nxt = BUF_FULL;
                    w_s_nxt     = in_data;
                end else if (out_ready) begin
                    w_state_nxt = BUF_EMPTY;
                end
            end
            BUF_FULL: begin
                if (out_ready) begin
                    w_state_nxt = BUF_ONE;
                    w_m_nxt     = r_s_data;
                    w_s_nxt     = '0;
                end
            end
            default: begin
                w_state_nxt = BUF_EMPTY;
            end
        endcase
    end

    a_no_skid_without_main: assert property (@(posedge clk) disable iff (reset)
        w_state_bits != 2'b01);

endmodule

// File: rtl/dec_onehot_pipe.sv
// Registered index decoder (one-hot or thermometer) behind a skid buffer, with
// out-of-range flagging and a saturating count of accepted bad indices.
module dec_onehot_pipe
    import dec_pkg::*;
#(
    parameter int unsigned IN_W  = 5,
    parameter int unsigned OUT_W = 32,
    parameter int unsigned MODE  = 0,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_idx,
    input  logic             in_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_vec,
    output logic             out_err,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int unsigned PAY_W = OUT_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    if (IN_W < 1 || IN_W > DEC_IDX_W) begin : g_bad_in_w
        $error("dec_onehot_pipe: IN_W must be in 1..8");
    end
    if (OUT_W < 1 || OUT_W > (32'd1 << IN_W)) begin : g_bad_out_w
        $error("dec_onehot_pipe: OUT_W must satisfy 1 <= OUT_W <= 2**IN_W");
    end
    if (MODE > MODE_THERMO) begin : g_bad_mode
        $error("dec_onehot_pipe: MODE must be 0 or 1");
    end

    dec_res_t         w_dec;
    logic [PAY_W-1:0] w_payload;
    logic [PAY_W-1:0] w_out_data;
    logic             w_in_fire;
    logic [CNT_W-1:0] r_err_cnt;

    assign w_dec     = dec_vec(DEC_IDX_W'(in_idx), in_en, OUT_W, MODE);
    assign w_payload = {w_dec.err, w_dec.vec[OUT_W-1:0]};
    assign w_in_fire = in_valid && in_ready;

    // Bits above OUT_W are always zero from dec_vec.
    if (OUT_W < DEC_MAX_W) begin : g_unused
        logic w_unused_hi;
        assign w_unused_hi = ^w_dec.vec[DEC_MAX_W-1:OUT_W];
    end

    dec_skid_buf #(
        .DATA_W(PAY_W)
    ) u_skid (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (w_payload),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (w_out_data)
    );

    assign out_vec = w_out_data[OUT_W-1:0];
    assign out_err = w_out_data[OUT_W];
    assign err_cnt = r_err_cnt;

    // Errors are counted when the index is accepted, not when it is delivered.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_cnt <= '0;
        end else if (w_in_fire && w_dec.err && (r_err_cnt != CNT_MAX)) begin
            r_err_cnt <= r_err_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_dec_onehot_pipe.sv
// Bench for dec_onehot_pipe: directed sweeps on three configurations, then a
// randomized stall stress against a queue-based reference model.
module tb_dec_onehot_pipe;

    logic clk;
    logic reset;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A: IN_W=5, OUT_W=32, one-hot, CNT_W=8
    logic        a_in_valid, a_in_ready, a_in_en, a_out_valid, a_out_ready, a_out_err;
    logic [4:0]  a_in_idx;
    logic [31:0] a_out_vec;
    logic [7:0]  a_err_cnt;
    // B: IN_W=3, OUT_W=6, thermometer, CNT_W=8
    logic        b_in_valid, b_in_ready, b_in_en, b_out_valid, b_out_ready, b_out_err;
    logic [2:0]  b_in_idx;
    logic [5:0]  b_out_vec;
    logic [7:0]  b_err_cnt;
    // C: IN_W=3, OUT_W=4, one-hot, CNT_W=2
    logic        c_in_valid, c_in_ready, c_in_en, c_out_valid, c_out_ready, c_out_err;
    logic [2:0]  c_in_idx;
    logic [3:0]  c_out_vec;
    logic [1:0]  c_err_cnt;

    dec_onehot_pipe #(.IN_W(5), .OUT_W(32), .MODE(0), .CNT_W(8)) u_a (
        .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_idx(a_in_idx), .in_en(a_in_en), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_vec(a_out_vec), .out_err(a_out_err), .err_cnt(a_err_cnt)
    );
    dec_onehot_pipe #(.IN_W(3), .OUT_W(6), .MODE(1), .CNT_W(8)) u_b (
        .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_idx(b_in_idx), .in_en(b_in_en), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_vec(b_out_vec), .out_err(b_out_err), .err_cnt(b_err_cnt)
    );
    dec_onehot_pipe #(.IN_W(3), .OUT_W(4), .MODE(0), .CNT_W(2)) u_c (
        .clk(clk), .reset(reset), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_idx(c_in_idx), .in_en(c_in_en), .out_valid(c_out_valid), .out_ready(c_out_ready),
        .out_vec(c_out_vec), .out_err(c_out_err), .err_cnt(c_err_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference decode from the rules: returns {err, vec}.
    function automatic logic [64:0] ref_dec(input int unsigned idx, input bit en,
                                            input int unsigned out_w, input int unsigned mode);
        if (!en) return 65'd0;
        if (idx >= out_w) return {1'b1, 64'd0};
        if (mode == 1) return {1'b0, (64'd1 << (idx + 1)) - 64'd1};
        return {1'b0, 64'd1 << idx};
    endfunction

    // Thermometer / out-of-range table for B.
    int unsigned t_idx [5] = '{2, 5, 6, 7, 7};
    bit          t_en  [5] = '{1, 1, 1, 1, 0};
    logic [5:0]  t_vec [5] = '{6'b000111, 6'b111111, 6'b000000, 6'b000000, 6'b000000};
    bit          t_err [5] = '{0, 0, 1, 1, 0};
    int unsigned t_cnt [5] = '{0, 0, 1, 2, 2};

    logic [64:0] q[$];
    logic [64:0] e;
    int unsigned m_cnt;
    bit          hold, in_fire, out_fire;

    initial begin
        reset = 1'b1;
        a_in_valid = 0; a_in_en = 0; a_in_idx = '0; a_out_ready = 0;
        b_in_valid = 0; b_in_en = 0; b_in_idx = '0; b_out_ready = 0;
        c_in_valid = 0; c_in_en = 0; c_in_idx = '0; c_out_ready = 0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 64'(a_out_valid), 64'd0);
        chk("rst_out_vec",   64'(a_out_vec),   64'd0);
        chk("rst_out_err",   64'(a_out_err),   64'd0);
        chk("rst_err_cnt",   64'(a_err_cnt),   64'd0);
        chk("rst_in_ready",  64'(a_in_ready),  64'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(a_in_ready), 64'd1);

        // One-hot sweep, back-to-back with no bubbles
        a_out_ready = 1'b1;
        a_in_en     = 1'b1;
        for (int k = 0; k <= 33; k++) begin
            if (k > 0) @(negedge clk);
            if (k >= 1 && k <= 32) begin
                chk("sweep_valid", 64'(a_out_valid), 64'd1);
                chk("sweep_vec",   64'(a_out_vec),   64'd1 << (k - 1));
                chk("sweep_err",   64'(a_out_err),   64'd0);
            end
            if (k < 32) chk("sweep_in_ready", 64'(a_in_ready), 64'd1);
            if (k == 33) chk("sweep_drained", 64'(a_out_valid), 64'd0);
            a_in_valid = (k < 32);
            a_in_idx   = 5'(k);
        end
        chk("sweep_err_cnt", 64'(a_err_cnt), 64'd0);

        // Thermometer and out-of-range
        b_out_ready = 1'b1;
        for (int k = 0; k <= 5; k++) begin
            if (k > 0) @(negedge clk);
            if (k >= 1) begin
                chk("therm_valid", 64'(b_out_valid), 64'd1);
                chk("therm_vec",   64'(b_out_vec),   64'(t_vec[k-1]));
                chk("therm_err",   64'(b_out_err),   64'(t_err[k-1]));
                chk("therm_cnt",   64'(b_err_cnt),   64'(t_cnt[k-1]));
            end
            b_in_valid = (k < 5);
            if (k < 5) begin
                b_in_idx = 3'(t_idx[k]);
                b_in_en  = t_en[k];
            end
        end

        // Backpressure: idx 3,4,5 with out_ready low
        @(negedge clk);
        a_out_ready = 1'b0;
        chk("bp_ready0", 64'(a_in_ready), 64'd1);
        a_in_valid = 1'b1; a_in_idx = 5'd3;
        @(negedge clk);
        chk("bp_valid1", 64'(a_out_valid), 64'd1);
        chk("bp_vec1",   64'(a_out_vec),   64'd8);
        chk("bp_ready1", 64'(a_in_ready),  64'd1);
        a_in_idx = 5'd4;
        @(negedge clk);
        chk("bp_full_ready", 64'(a_in_ready), 64'd0);
        chk("bp_vec2",       64'(a_out_vec),  64'd8);
        a_in_idx = 5'd5;
        @(negedge clk);
        chk("bp_held_ready", 64'(a_in_ready), 64'd0);
        chk("bp_vec_stable", 64'(a_out_vec),  64'd8);
        a_out_ready = 1'b1;
        @(negedge clk);
        chk("bp_vec4",   64'(a_out_vec),  64'd16);
        chk("bp_ready4", 64'(a_in_ready), 64'd1);
        @(negedge clk);
        chk("bp_vec5",   64'(a_out_vec),   64'd32);
        chk("bp_valid5", 64'(a_out_valid), 64'd1);
        a_in_valid = 1'b0;
        @(negedge clk);
        chk("bp_drained", 64'(a_out_valid), 64'd0);

        // Error counter saturation on a 2-bit counter
        c_out_ready = 1'b1; c_in_en = 1'b1; c_in_idx = 3'd7;
        for (int k = 0; k <= 5; k++) begin
            if (k > 0) @(negedge clk);
            if (k >= 1) begin
                chk("sat_cnt", 64'(c_err_cnt), 64'((k < 3) ? k : 3));
                chk("sat_err", 64'(c_out_err), 64'd1);
                chk("sat_vec", 64'(c_out_vec), 64'd0);
            end
            c_in_valid = (k < 5);
        end

        // Reset with the buffer full; the reset-cycle transfer is discarded
        @(negedge clk);
        c_out_ready = 1'b0; c_in_valid = 1'b1; c_in_idx = 3'd1;
        @(negedge clk);
        c_in_idx = 3'd2;
        @(negedge clk);
        chk("mid_full_ready", 64'(c_in_ready),  64'd0);
        chk("mid_full_valid", 64'(c_out_valid), 64'd1);
        reset = 1'b1; c_in_idx = 3'd7; c_out_ready = 1'b1;
        #1;
        chk("mid_rst_ready", 64'(c_in_ready), 64'd0);
        @(negedge clk);
        chk("mid_rst_valid", 64'(c_out_valid), 64'd0);
        chk("mid_rst_vec",   64'(c_out_vec),   64'd0);
        chk("mid_rst_err",   64'(c_out_err),   64'd0);
        chk("mid_rst_cnt",   64'(c_err_cnt),   64'd0);
        reset = 1'b0; c_in_valid = 1'b0;
        #1;
        chk("mid_post_ready", 64'(c_in_ready), 64'd1);
        @(negedge clk);
        chk("mid_ignored_valid", 64'(c_out_valid), 64'd0);
        chk("mid_ignored_cnt",   64'(c_err_cnt),   64'd0);

        // Random stall stress on the thermometer instance
        m_cnt = 0; hold = 0; b_in_valid = 0; b_out_ready = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            @(negedge clk);
            chk("stress_valid", 64'(b_out_valid), 64'(q.size() != 0));
            chk("stress_ready", 64'(b_in_ready),  64'(q.size() < 2));
            chk("stress_cnt",   64'(b_err_cnt),   64'(m_cnt));
            if (q.size() != 0) begin
                chk("stress_vec", 64'(b_out_vec), q[0][63:0]);
                chk("stress_err", 64'(b_out_err), 64'(q[0][64]));
            end
            b_out_ready = ($urandom_range(0, 1) != 0);
            if (!hold) begin
                b_in_valid = ($urandom_range(0, 3) != 0);
                b_in_idx   = 3'($urandom_range(0, 7));
                b_in_en    = ($urandom_range(0, 7) != 0);
            end
            in_fire  = b_in_valid && (q.size() < 2);
            out_fire = b_out_ready && (q.size() != 0);
            if (out_fire) void'(q.pop_front());
            if (in_fire) begin
                e = ref_dec(32'(b_in_idx), b_in_en, 6, 1);
                q.push_back(e);
                if (e[64] && m_cnt < 255) m_cnt++;
            end
            hold = b_in_valid && !in_fire;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
